// File: rtl/gpio_pkg.sv
// Shared constants and helpers for the GPIO input-conditioning slice:
// bank widths, filter defaults and the debounce counter width rule.
package gpio_pkg;

    localparam int GPIO_SYNC_STAGES_DEFAULT = 2;
    localparam int GPIO_DEBOUNCE_DEFAULT    = 16;
    localparam int GPIO_STATUS_WIDTH        = 5;
    localparam int GPIO0_WIDTH              = 12;

    // One-cycle edge flags registered alongside the accepted pin level.
    typedef struct packed {
        logic rise;
        logic fall;
    } edgePulse_t;

    // The counter must hold 0 .. DEBOUNCE_CYCLES-1 without wrapping.
    function automatic int gpioCntWidth(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/gpio_debounce_bit.sv
// Single-pin conditioning: synchronizer chain, debounce counter and
// registered rise/fall pulses that appear with the new level.
module gpio_debounce_bit
    import gpio_pkg::*;
#(
    parameter int   SYNC_STAGES     = GPIO_SYNC_STAGES_DEFAULT,
    parameter int   DEBOUNCE_CYCLES = GPIO_DEBOUNCE_DEFAULT,
    parameter logic RESET_BIT       = 1'b0,
    parameter int   CNT_W           = gpioCntWidth(DEBOUNCE_CYCLES)
) (
    input  logic io_clock,
    input  logic io_reset,
    input  logic pinRaw,
    input  logic bypass,
    output logic pinRead,
    output logic rise,
    output logic fall
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] syncChain;
    logic                   synced;
    logic [CNT_W-1:0]       cnt;
    edgePulse_t             edgeQ;

    assign synced = syncChain[SYNC_STAGES-1];
    assign rise   = edgeQ.rise;
    assign fall   = edgeQ.fall;

    // NOTE: the chain resets to the same value as pinRead so that releasing
    // reset never looks like a level change and never fires a false edge.
    always_ff @(posedge io_clock or negedge io_reset) begin
        if (!io_reset) begin
            syncChain <= {SYNC_STAGES{RESET_BIT}};
        end else begin
            syncChain <= {syncChain[SYNC_STAGES-2:0], pinRaw};
        end
    end

    // Level compare is evaluated before the expiry check, so a sample that
    // returns to the current level on the expiry cycle cancels the update.
    always_ff @(posedge io_clock or negedge io_reset) begin
        if (!io_reset) begin
            cnt     <= '0;
            pinRead <= RESET_BIT;
            edgeQ   <= '0;
        end else begin
            // NOTE: pulses default low every cycle so each lasts exactly one.
            edgeQ <= '0;
            if (bypass) begin
                cnt        <= '0;
                pinRead    <= synced;
                edgeQ.rise <= synced & ~pinRead;
                edgeQ.fall <= ~synced & pinRead;
            end else if (synced == pinRead) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt        <= '0;
                pinRead    <= synced;
                edgeQ.rise <= synced;
                edgeQ.fall <= ~synced;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/gpio_input_debounce.sv
// GPIO bank input conditioning between the pad buffers and the SoC pin-read
// inputs: one independent synchronizer + debounce filter per pin.
module gpio_input_debounce
    import gpio_pkg::*;
#(
    parameter int               WIDTH           = GPIO_STATUS_WIDTH,
    parameter int               SYNC_STAGES     = GPIO_SYNC_STAGES_DEFAULT,
    parameter int               DEBOUNCE_CYCLES = GPIO_DEBOUNCE_DEFAULT,
    parameter logic [WIDTH-1:0] RESET_VALUE     = {WIDTH{1'b0}},
    parameter int               CNT_W           = gpioCntWidth(DEBOUNCE_CYCLES)
) (
    input  logic             io_clock,
    input  logic             io_reset,
    input  logic [WIDTH-1:0] pins_raw,
    input  logic [WIDTH-1:0] bypass,
    output logic [WIDTH-1:0] pins_read,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    for (genvar i = 0; i < WIDTH; i++) begin : gPin
        gpio_debounce_bit #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .RESET_BIT      (RESET_VALUE[i]),
            .CNT_W          (CNT_W)
        ) uBit (
            .io_clock(io_clock),
            .io_reset(io_reset),
            .pinRaw  (pins_raw[i]),
            .bypass  (bypass[i]),
            .pinRead (pins_read[i]),
            .rise    (rise[i]),
            .fall    (fall[i])
        );
    end

endmodule

// File: tb/tb_gpio_input_debounce.sv
// Bench for gpio_input_debounce: each scenario queues the edge events it
// expects; a negedge monitor pops one entry for every pulse the DUT emits.
module tb_gpio_input_debounce;

    logic       io_clock;
    logic       io_reset;
    logic [4:0] pins_raw;
    logic [4:0] bypass;
    logic [4:0] pins_read;
    logic [4:0] rise;
    logic [4:0] fall;

    int nAssert = 0;
    int nFail   = 0;
    int cycle   = 0;

    typedef struct {
        int         cyc;
        logic [4:0] rise;
        logic [4:0] fall;
        logic [4:0] read;
    } sbEntry_t;

    sbEntry_t sbQ[$];
    sbEntry_t monExp;

    gpio_input_debounce #(
        .WIDTH          (5),
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(16),
        .RESET_VALUE    (5'h00)
    ) dut (
        .io_clock (io_clock),
        .io_reset (io_reset),
        .pins_raw (pins_raw),
        .bypass   (bypass),
        .pins_read(pins_read),
        .rise     (rise),
        .fall     (fall)
    );

    initial begin
        io_clock = 1'b0;
        forever #5 io_clock = ~io_clock;
    end

    always @(posedge io_clock) cycle <= cycle + 1;

    // Scoreboard consumer: every observed pulse must match the next queued event.
    always @(negedge io_clock) begin
        if ((rise | fall) != 5'h00) begin
            nAssert++;
            if (sbQ.size() == 0) begin
                nFail++;
                $display("FAIL unexpected_pulse: cycle %0d rise %h fall %h read %h, none queued",
                         cycle, rise, fall, pins_read);
            end else begin
                monExp = sbQ.pop_front();
                if (cycle !== monExp.cyc || rise !== monExp.rise ||
                    fall !== monExp.fall || pins_read !== monExp.read) begin
                    nFail++;
                    $display("FAIL edge_event: got cycle %0d rise %h fall %h read %h, expected cycle %0d rise %h fall %h read %h",
                             cycle, rise, fall, pins_read,
                             monExp.cyc, monExp.rise, monExp.fall, monExp.read);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge io_clock);
    endtask

    task automatic pushExp(input int cyc, input logic [4:0] r, input logic [4:0] f,
                           input logic [4:0] rd);
        sbEntry_t e;
        e.cyc  = cyc;
        e.rise = r;
        e.fall = f;
        e.read = rd;
        sbQ.push_back(e);
    endtask

    task automatic checkDrained(input string name);
        nAssert++;
        if (sbQ.size() != 0) begin
            nFail++;
            $display("FAIL %s_missing_events: %0d queued events never observed, expected 0",
                     name, sbQ.size());
            sbQ.delete();
        end
    endtask

    task automatic test_reset();
        int c;
        io_reset = 1'b0;
        pins_raw = 5'h1F;
        bypass   = 5'h00;
        tick(4);
        nAssert++;
        if (pins_read !== 5'h00) begin nFail++; $display("FAIL reset_pins_read: got %h expected 00", pins_read); end
        nAssert++;
        if (rise !== 5'h00) begin nFail++; $display("FAIL reset_rise: got %h expected 00", rise); end
        nAssert++;
        if (fall !== 5'h00) begin nFail++; $display("FAIL reset_fall: got %h expected 00", fall); end
        io_reset = 1'b1;
        c = cycle;
        pushExp(c + 18, 5'h1F, 5'h00, 5'h1F);
        tick(17);
        nAssert++;
        if (pins_read !== 5'h00) begin nFail++; $display("FAIL release_early: got %h expected 00", pins_read); end
        tick(1);
        nAssert++;
        if (pins_read !== 5'h1F) begin nFail++; $display("FAIL release_level: got %h expected 1f", pins_read); end
        tick(1);
        nAssert++;
        if (rise !== 5'h00) begin nFail++; $display("FAIL release_rise_width: got %h expected 00", rise); end
        tick(2);
        checkDrained("reset");
    endtask

    task automatic reReset();
        io_reset = 1'b0;
        pins_raw = 5'h00;
        bypass   = 5'h00;
        tick(3);
        io_reset = 1'b1;
        tick(4);
    endtask

    task automatic test_clean_step();
        int c;
        reReset();
        pins_raw[0] = 1'b1;
        c = cycle;
        pushExp(c + 18, 5'h01, 5'h00, 5'h01);
        tick(17);
        nAssert++;
        if (pins_read !== 5'h00) begin nFail++; $display("FAIL step_early: got %h expected 00", pins_read); end
        tick(1);
        nAssert++;
        if (pins_read !== 5'h01) begin nFail++; $display("FAIL step_level: got %h expected 01", pins_read); end
        nAssert++;
        if (fall !== 5'h00) begin nFail++; $display("FAIL step_fall: got %h expected 00", fall); end
        tick(1);
        nAssert++;
        if (rise !== 5'h00) begin nFail++; $display("FAIL step_rise_width: got %h expected 00", rise); end
        checkDrained("clean_step");
    endtask

    task automatic test_glitch_boundary();
        int c;
        pins_raw[1] = 1'b1;
        tick(15);
        pins_raw[1] = 1'b0;
        tick(25);
        nAssert++;
        if (pins_read !== 5'h01) begin nFail++; $display("FAIL glitch15_rejected: got %h expected 01", pins_read); end
        pins_raw[1] = 1'b1;
        c = cycle;
        pushExp(c + 18, 5'h02, 5'h00, 5'h03);
        pushExp(c + 34, 5'h00, 5'h02, 5'h01);
        tick(16);
        pins_raw[1] = 1'b0;
        tick(2);
        nAssert++;
        if (pins_read !== 5'h03) begin nFail++; $display("FAIL glitch16_accepted: got %h expected 03", pins_read); end
        tick(20);
        nAssert++;
        if (pins_read !== 5'h01) begin nFail++; $display("FAIL glitch16_falls: got %h expected 01", pins_read); end
        checkDrained("glitch");
    endtask

    task automatic test_bypass();
        int c;
        bypass = 5'b00100;
        tick(2);
        pins_raw[2] = 1'b1;
        c = cycle;
        pushExp(c + 3, 5'h04, 5'h00, 5'h05);
        tick(2);
        nAssert++;
        if (pins_read !== 5'h01) begin nFail++; $display("FAIL bypass_early: got %h expected 01", pins_read); end
        tick(1);
        nAssert++;
        if (pins_read !== 5'h05) begin nFail++; $display("FAIL bypass_level: got %h expected 05", pins_read); end
        tick(3);
        pins_raw[2] = 1'b0;
        c = cycle;
        pushExp(c + 3, 5'h00, 5'h04, 5'h01);
        tick(6);
        pins_raw[2] = 1'b1;
        c = cycle;
        pushExp(c + 3, 5'h04, 5'h00, 5'h05);
        pushExp(c + 4, 5'h00, 5'h04, 5'h01);
        tick(1);
        pins_raw[2] = 1'b0;
        tick(8);
        nAssert++;
        if (pins_read !== 5'h01) begin nFail++; $display("FAIL bypass_glitch_end: got %h expected 01", pins_read); end
        bypass = 5'h00;
        tick(2);
        checkDrained("bypass");
    endtask

    task automatic test_reset_mid_count();
        pins_raw[3] = 1'b1;
        tick(12);
        io_reset = 1'b0;
        pins_raw = 5'h00;
        #1;
        nAssert++;
        if (pins_read !== 5'h00) begin nFail++; $display("FAIL midreset_level: got %h expected 00", pins_read); end
        nAssert++;
        if ((rise | fall) !== 5'h00) begin nFail++; $display("FAIL midreset_pulse: got rise %h fall %h expected 00", rise, fall); end
        tick(3);
        io_reset = 1'b1;
        tick(25);
        nAssert++;
        if (pins_read !== 5'h00) begin nFail++; $display("FAIL midreset_after: got %h expected 00", pins_read); end
        checkDrained("reset_mid_count");
    endtask

    task automatic test_simultaneous();
        int c;
        pins_raw = 5'h1F;
        c = cycle;
        pushExp(c + 18, 5'h0F, 5'h00, 5'h0F);
        tick(15);
        pins_raw[4] = 1'b0;
        tick(3);
        nAssert++;
        if (pins_read !== 5'h0F) begin nFail++; $display("FAIL simul_level: got %h expected 0f", pins_read); end
        pins_raw[4] = 1'b1;
        c = cycle;
        pushExp(c + 18, 5'h10, 5'h00, 5'h1F);
        tick(17);
        nAssert++;
        if (pins_read !== 5'h0F) begin nFail++; $display("FAIL simul_restart_early: got %h expected 0f", pins_read); end
        tick(1);
        nAssert++;
        if (pins_read !== 5'h1F) begin nFail++; $display("FAIL simul_restart_level: got %h expected 1f", pins_read); end
        tick(2);
        checkDrained("simultaneous");
    endtask

    initial begin
        io_reset = 1'b0;
        pins_raw = 5'h00;
        bypass   = 5'h00;
        test_reset();
        test_clean_step();
        test_glitch_boundary();
        test_bypass();
        test_reset_mid_count();
        test_simultaneous();
        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule

// File: doc/gpio_input_debounce.md
Name: gpio_input_debounce

Overview:
- Input-conditioning stage between the board pad tri-state buffers and the Hydrogen SoC `io_gpioStatus_pins_read` / `io_gpio0_pins_read` inputs.
- Each pad input passes through a multi-flop synchronizer and a per-pin debounce counter.
- Outputs are clean, glitch-free pin levels plus one-cycle rise and fall pulses for SoC interrupt or edge logic.
- Instantiated once per GPIO bank in the board top level.

Parameters:
- WIDTH, 5: number of pins in the bank.
- SYNC_STAGES, 2: synchronizer flop depth; legal values are 2 or more.
- DEBOUNCE_CYCLES, 16: consecutive differing synced samples needed to accept a new level; legal values are 1 or more.
- RESET_VALUE, {WIDTH{1'b0}}: value of pins_read during and after reset.
- CNT_W, $clog2(DEBOUNCE_CYCLES+1): counter width; derived, do not override.

Ports:
- io_clock  input  1  single system clock; all flops rise-edge.
- io_reset  input  1  reset, asynchronous assert, active-low (0 = reset); release is synchronized externally.
- pins_raw  input  WIDTH  asynchronous pad levels from the tri-state buffers.
- bypass  input  WIDTH  per-pin: 1 = skip the debounce filter (the synchronizer is always kept).
- pins_read  output  WIDTH  debounced stable levels to the SoC.
- rise  output  WIDTH  one-cycle pulse when pins_read[i] goes 0->1.
- fall  output  WIDTH  one-cycle pulse when pins_read[i] goes 1->0.

Behaviour:
- Reset (io_reset=0, asynchronous):
  - All synchronizer flops go to RESET_VALUE, so no false edge on release.
  - Counters go to 0.
  - pins_read = RESET_VALUE.
  - rise = 0, fall = 0.
  - All state is cleared when reset asserts mid-count; no edge pulse is emitted on reset entry or exit.
- Synchronizer: a shift chain of SYNC_STAGES flops per pin. Call the last stage's output s[i].
- Per-pin filter, each cycle, when bypass[i]=0:
  - If s[i]==pins_read[i]: cnt[i] <= 0, so any glitch is discarded.
  - Else, if cnt[i]==DEBOUNCE_CYCLES-1: pins_read[i] <= s[i], cnt[i] <= 0, and the matching edge pulse is registered for the next cycle.
  - Else: cnt[i] <= cnt[i]+1.
  - The counter never wraps. Its maximum value is DEBOUNCE_CYCLES-1.
- Per-pin filter, each cycle, when bypass[i]=1:
  - pins_read[i] <= s[i] every cycle.
  - cnt[i] <= 0.
  - Edges are still generated.
- Toggling bypass mid-count: cnt is cleared when bypass=1. When bypass returns to 0, filtering restarts from the current pins_read.
- Edge pulses:
  - rise/fall are registered together with the pins_read update and are valid in the same cycle the new level appears.
  - Each pulse is high for exactly one cycle.
  - rise and fall are never both high on one pin.
- Latency, from a clean raw step arriving before clock edge 1:
  - Filtered: pins_read changes after edge SYNC_STAGES+DEBOUNCE_CYCLES. Defaults give 18 edges.
  - Bypass: pins_read changes after edge SYNC_STAGES+1. Defaults give 3 edges.
- Glitch rejection: a synced pulse lasting DEBOUNCE_CYCLES-1 cycles or fewer produces no output change. A pulse lasting exactly DEBOUNCE_CYCLES cycles is accepted.
- Pin independence: pins are fully independent; simultaneous changes on several pins each follow their own counter.
- Ordering of simultaneous events: when s[i] returns to pins_read[i] in the same cycle the counter would expire, no update occurs, because the compare happens before the expiry check.
- Output logic: no combinational path from pins_raw to any output; all outputs are registered.

Decomposition:
- Shared package gpio_pkg:
  - GPIO_SYNC_STAGES_DEFAULT = 2
  - GPIO_DEBOUNCE_DEFAULT = 16
  - GPIO_STATUS_WIDTH = 5
  - GPIO0_WIDTH = 12
  - a clog2-based counter-width helper.
- One natural sub-module: gpio_debounce_bit, a single-pin synchronizer, counter and edge register.
  - Parameters: SYNC_STAGES, DEBOUNCE_CYCLES, RESET_BIT.
  - The top module instantiates it with a generate loop over WIDTH.

Test Plan:
1. Reset and release: hold io_reset=0 with pins_raw=5'h1F, then release. pins_read=5'h00 and rise/fall=0 during reset. pins_read[4:0]=5'h1F 18 edges after release, with rise=5'h1F for exactly 1 cycle.
2. Clean step: pins_raw[0] 0->1 with defaults. pins_read[0] rises on edge 18, rise[0]=1 for 1 cycle, fall=0, and other pins are unchanged.
3. Glitch boundary: raw pulses on pin 1 of 15 cycles, then 16 cycles (synchronous drive). The 15-cycle pulse leaves pins_read[1] unchanged with no pulse. The 16-cycle pulse makes pins_read[1] go high, then low again after the falling debounce, with rise[1] then fall[1].
4. Bypass: bypass=5'b00100, toggle pins_raw[2]. pins_read[2] follows with 3-edge latency and rise/fall pulse per transition. A 1-cycle glitch passes through.
5. Reset mid-count: pin 3 counter at 10, assert io_reset. cnt=0 and pins_read[3]=0 immediately (asynchronous), and no pulse after release while raw=0.
6. Simultaneous pins: all 5 pins step together, with pin 4 glitching back at cycle 17. Pins 0-3 update on edge 18 with rise=5'b01111. Pin 4 is unchanged, and its counter restarts on the next difference.
